tx_controller: RTL and testbench

UART transmitter for the board serial port, the transmit counterpart of the UART receive path feeding text memory. It accepts bytes from the processor/IO side through a small FIFO. It serialises each byte onto `UART_TXD` as 8N1 frames (1 start, 8 data LSB-first, 1 stop) at a fixed bit period. It reports space, activity and per-frame completion back to the writer.

---
 rtl/tx_controller.sv | 165 ++++++++++++++++
 tb/tb_tx_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_controller.sv
// UART 8N1 transmitter with a small byte FIFO in front of the serialiser.
// UART_TXD is registered; TX_DONE marks the last cycle of every stop bit.
module tx_controller #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       TX_READY,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       UART_TXD
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic push, pop, baud_end, have_data;

    // Readiness looks at the current count only, so a full FIFO refuses a
    // write even in a cycle where the serialiser pops.
    assign TX_READY  = (count_q < DEPTH);
    assign push      = TX_START && TX_READY;
    assign have_data = (count_q != '0);
    assign baud_end  = (baud_q == BAUD_LAST);

    assign TX_BUSY  = (state_q != IDLE) || have_data;
    assign TX_DONE  = (state_q == STOP) && baud_end;
    assign UART_TXD = txd_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= TX_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so the output flop tracks
    // the FSM without an extra cycle of lag.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_tx_controller.sv
// Scoreboard bench for tx_controller: expected bytes queued at write time,
// a line monitor checks every frame cycle and pops the scoreboard.
module tb_tx_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data1, data2;
    logic       start1, start2;
    logic       ready1, busy1, done1, txd1;
    logic       ready2, busy2, done2, txd2;

    tx_controller #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .TX_DATA(data1), .TX_START(start1),
        .TX_READY(ready1), .TX_BUSY(busy1), .TX_DONE(done1), .UART_TXD(txd1)
    );

    tx_controller #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .TX_DATA(data2), .TX_START(start2),
        .TX_READY(ready2), .TX_BUSY(busy2), .TX_DONE(done2), .UART_TXD(txd2)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int done_t[$];
    int done_cnt = 0;
    int cyc = 0;
    logic sel = 1'b0;
    logic mon_en = 1'b0;

    logic m_txd, m_done;
    assign m_txd  = sel ? txd2 : txd1;
    assign m_done = sel ? done2 : done1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int target, input int lim);
        int i = 0;
        while (done_cnt < target && i < lim) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("done_count", done_cnt, target);
    endtask

    // Line monitor: every cycle of a frame is compared to the expected bit.
    initial begin
        int fcnt;
        int cpb;
        logic in_frm;
        logic [9:0] frm;
        in_frm = 1'b0;
        fcnt = 0;
        frm = '1;
        forever begin
            @(negedge clk);
            cyc++;
            cpb = sel ? 2 : 4;
            if (!rst_n || !mon_en) begin
                in_frm = 1'b0;
            end else begin
                if (m_done) begin
                    done_cnt++;
                    done_t.push_back(cyc);
                end
                if (!in_frm && m_txd === 1'b0) begin
                    in_frm = 1'b1;
                    fcnt = 0;
                    chk("sb_nonempty", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) frm = {1'b1, exp_q.pop_front(), 1'b0};
                    else frm = {1'b1, 8'h00, 1'b0};
                end
                if (in_frm) begin
                    chk("txd", m_txd, frm[fcnt / cpb]);
                    chk("done", m_done, (fcnt == 10 * cpb - 1));
                    if (fcnt == 10 * cpb - 1) in_frm = 1'b0;
                    else fcnt++;
                end else begin
                    chk("done_idle", m_done, 0);
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        int g;
        rst_n = 1'b0;
        data1 = '0; start1 = 1'b0;
        data2 = '0; start2 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd1, 1);
        chk("rst_ready", ready1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_txd2", txd2, 1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_txd", txd1, 1);
        end

        // Single byte 0xA5
        base = done_cnt;
        exp_q.push_back(8'hA5);
        data1 = 8'hA5; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("lat_txd_hi", txd1, 1);
        chk("lat_busy", busy1, 1);
        @(negedge clk);
        chk("lat_txd_lo", txd1, 0);
        wait_done(base + 1, 100);
        chk("busy_at_done", busy1, 1);
        @(negedge clk);
        chk("busy_fall", busy1, 0);
        chk("txd_idle", txd1, 1);

        // Back-to-back 0x00, 0xFF, 0x55
        repeat (5) @(negedge clk);
        done_t.delete();
        base = done_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        data1 = 8'h00; start1 = 1'b1;
        @(negedge clk);
        data1 = 8'hFF;
        @(negedge clk);
        data1 = 8'h55;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(base + 3, 200);
        chk("b2b_pulses", done_t.size(), 3);
        if (done_t.size() == 3) begin
            chk("b2b_gap01", done_t[1] - done_t[0], 40);
            chk("b2b_gap12", done_t[2] - done_t[1], 40);
        end
        @(negedge clk);
        chk("b2b_busy", busy1, 0);

        // FIFO full: 0x06 must be dropped
        repeat (5) @(negedge clk);
        base = done_cnt;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 6; i++) begin
            data1 = 8'(i);
            start1 = 1'b1;
            chk(i == 6 ? "ready_full" : "ready_open", ready1, (i == 6) ? 0 : 1);
            @(negedge clk);
        end
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        chk("ready_held", ready1, 0);
        wait_done(base + 5, 300);
        @(negedge clk);
        chk("full_busy", busy1, 0);
        chk("full_ready", ready1, 1);
        repeat (50) @(negedge clk);
        chk("full_sb_empty", exp_q.size(), 0);
        chk("full_extra", done_cnt, base + 5);

        // Reset mid-frame during DATA bit 3 of 0x3C with 2 queued
        mon_en = 1'b0;
        data1 = 8'h3C; start1 = 1'b1;
        @(negedge clk);
        data1 = 8'h11;
        @(negedge clk);
        data1 = 8'h22;
        @(negedge clk);
        chk("mid_start", txd1, 0);
        start1 = 1'b0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("mid_bit1", txd1, 0);
        repeat (8) @(negedge clk);
        chk("mid_bit3", txd1, 1);
        chk("mid_busy", busy1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_txd", txd1, 1);
        chk("arst_busy", busy1, 0);
        chk("arst_ready", ready1, 1);
        chk("arst_done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_txd", txd1, 1);
            chk("post_rst_done", done1, 0);
            chk("post_rst_busy", busy1, 0);
        end

        // Wrap-around on the CLKS_PER_BIT=2 instance
        sel = 1'b1;
        mon_en = 1'b1;
        base = done_cnt;
        n = 0;
        g = 0;
        while (n < 12 && g < 2000) begin
            if (ready2) begin
                data2 = 8'(8'h10 + n);
                start2 = 1'b1;
                exp_q.push_back(8'(8'h10 + n));
                n++;
            end else begin
                start2 = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        start2 = 1'b0;
        chk("wrap_written", n, 12);
        wait_done(base + 12, 400);
        @(negedge clk);
        chk("wrap_busy", busy2, 0);
        chk("wrap_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
